// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline forwarding/hazard controller:
//   - forwarding mux select encodings (register file, WB, MEM)
//   - REG_ZERO, the hard-wired zero register index
//   - slot_t, the per-stage destination metadata shadow record
//   - slot_writes(), true when a slot will write a given nonzero register
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Register-index width that the slot record is built with.
    localparam int SLOT_REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [SLOT_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_REG_W-1:0] rs;
        logic [SLOT_REG_W-1:0] rt;
        logic [SLOT_REG_W-1:0] dst;
        logic                  regwrite;
        logic                  memread;
    } slot_t;

    // A slot is a forwarding source for idx only if it really writes the
    // register file and the target is not the zero register.
    function automatic logic slot_writes(input slot_t s, input logic [SLOT_REG_W-1:0] idx);
        return s.valid & s.regwrite & (s.dst != REG_ZERO) & (s.dst == idx);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// ----------------------------------------------------------------------------
// fwd_select
// Combinational select generator for one ALU operand forwarding mux.
// Ports:
//   src      in   source register index of the instruction in EX
//   mem_slot in   metadata of the instruction in MEM
//   wb_slot  in   metadata of the instruction in WB
//   sel      out  FWD_MEM, FWD_WB or FWD_REG (never 2'b11)
// MEM is the younger producer, so it wins over WB.
// ----------------------------------------------------------------------------
module fwd_select
    import cpu_pkg::*;
(
    input  logic [SLOT_REG_W-1:0] src,
    input  slot_t                 mem_slot,
    input  slot_t                 wb_slot,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_REG;
        if (slot_writes(mem_slot, src)) begin
            sel = FWD_MEM;
        end else if (slot_writes(wb_slot, src)) begin
            sel = FWD_WB;
        end
    end

    // Source fields and the load flag of the later slots play no part in
    // the forwarding decision.
    logic unused_fields;
    assign unused_fields = ^{mem_slot.rs, mem_slot.rt, mem_slot.memread,
                             wb_slot.rs,  wb_slot.rt,  wb_slot.memread};

endmodule

// File: rtl/forward_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// forward_hazard_ctrl
// Forwarding and load-use stall controller for the EX-stage operand muxes.
// Keeps shadow copies of destination metadata for EX, MEM and WB that move
// in lockstep with the datapath pipeline registers.
// Parameters:
//   REG_W  register-index width (the slot record is built at SLOT_REG_W,
//          so REG_W must equal it)
//   CNT_W  width of the saturating stall counter
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   id_valid_i     ID holds a real instruction
//   id_rs_i/rt_i   source indices of the ID instruction
//   id_dst_i       resolved destination of the ID instruction
//   id_regwrite_i  ID instruction writes the register file
//   id_memread_i   ID instruction is a load
//   flush_i        discard the ID instruction (taken branch)
//   stall_o        hold PC and IF/ID, bubble into ID/EX
//   forward_a_o    operand A mux select
//   forward_b_o    operand B mux select
//   stall_cnt_o    saturating count of stall cycles
// ----------------------------------------------------------------------------
module forward_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W = SLOT_REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_dst_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       forward_a_o,
    output logic [1:0]       forward_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    slot_t            ex_reg;
    slot_t            mem_reg;
    slot_t            wb_reg;
    slot_t            ex_next;
    slot_t            mem_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             hazard;

    // Load in EX whose result the ID instruction needs: the value only
    // exists after MEM, so the consumer must wait one cycle.
    assign hazard = id_valid_i & ex_reg.valid & ex_reg.memread &
                    (ex_reg.dst != REG_ZERO) &
                    ((ex_reg.dst == id_rs_i) | (ex_reg.dst == id_rt_i));

    // A flushed instruction never executes, so it cannot cause a stall.
    assign stall_o = hazard & ~flush_i;

    always_comb begin
        ex_next = '0;
        if (id_valid_i & ~stall_o & ~flush_i) begin
            ex_next.valid    = 1'b1;
            ex_next.rs       = id_rs_i;
            ex_next.rt       = id_rt_i;
            ex_next.dst      = id_dst_i;
            ex_next.regwrite = id_regwrite_i;
            ex_next.memread  = id_memread_i;
        end
    end

    // MEM and WB only need what a forwarding source is judged on.
    always_comb begin
        mem_next          = '0;
        mem_next.valid    = ex_reg.valid;
        mem_next.dst      = ex_reg.dst;
        mem_next.regwrite = ex_reg.regwrite;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_reg        <= '0;
            mem_reg       <= '0;
            wb_reg        <= '0;
            stall_cnt_reg <= '0;
        end else begin
            ex_reg  <= ex_next;
            mem_reg <= mem_next;
            wb_reg  <= mem_reg;
            if (stall_o && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

    // Operand 0 is A (rs), operand 1 is B (rt).
    logic [1:0][SLOT_REG_W-1:0] src_idx;
    logic [1:0][1:0]            sel_raw;
    logic [1:0][1:0]            sel;

    assign src_idx[0] = ex_reg.rs;
    assign src_idx[1] = ex_reg.rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd_select (
                .src      (src_idx[gi]),
                .mem_slot (mem_reg),
                .wb_slot  (wb_reg),
                .sel      (sel_raw[gi])
            );
            // A bubble in EX reads nothing, so it must not steer the muxes.
            assign sel[gi] = ex_reg.valid ? sel_raw[gi] : FWD_REG;
        end
    endgenerate

    assign forward_a_o = sel[0];
    assign forward_b_o = sel[1];

endmodule
